// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit:
// operation encodings, controller states and the slice width.
package alu_pkg;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Width of the shared adder slice in bits
    localparam int NIB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add.sv
// Combinational NIB-bit adder slice with carry in and carry out.
// B inversion for subtraction and carry chaining are done by the caller.
module nibble_add
    import alu_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           cin,
    output logic [NIB-1:0] sum,
    output logic           cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIB{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_alu.sv
// WIDTH-bit add/subtract that reuses one NIB-bit adder slice over
// WIDTH/NIB cycles, least-significant nibble first. Result and flags
// are registered and only change when the last nibble completes.
module nibble_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int NNIB = WIDTH / NIB;
    localparam int IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NNIB - 1);

    state_t           state_reg;
    state_t           state_next;
    logic             accept;
    logic             last_nib;

    logic [IDXW-1:0]  idx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             op_reg;
    logic             chain_reg;
    logic [WIDTH-1:0] partial_reg;
    logic [WIDTH-1:0] partial_next;

    logic [NIB-1:0]   a_nibs [NNIB];
    logic [NIB-1:0]   b_nibs [NNIB];
    logic [NIB-1:0]   a_nib;
    logic [NIB-1:0]   b_eff;
    logic [NIB-1:0]   sum_nib;
    logic             cout_nib;

    // Split the latched operands into nibbles and splice the current
    // slice sum into the partial result at the active nibble position.
    generate
        for (genvar gi = 0; gi < NNIB; gi++) begin : g_nib
            assign a_nibs[gi] = a_reg[gi*NIB +: NIB];
            assign b_nibs[gi] = b_reg[gi*NIB +: NIB];
            assign partial_next[gi*NIB +: NIB] =
                (idx_reg == IDXW'(gi)) ? sum_nib : partial_reg[gi*NIB +: NIB];
        end
    endgenerate

    assign a_nib    = a_nibs[idx_reg];
    assign b_eff    = (op_reg == ALU_SUB) ? ~b_nibs[idx_reg] : b_nibs[idx_reg];
    assign last_nib = (idx_reg == LAST_IDX);

    nibble_add u_nibble_add (
        .a    (a_nib),
        .b    (b_eff),
        .cin  (chain_reg),
        .sum  (sum_nib),
        .cout (cout_nib)
    );

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-nibble accumulation and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= ALU_ADD;
            chain_reg   <= 1'b0;
            partial_reg <= '0;
            result      <= '0;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            zero        <= 1'b0;
        end else if (accept) begin
            a_reg       <= a;
            b_reg       <= b;
            op_reg      <= op;
            idx_reg     <= '0;
            partial_reg <= '0;
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry
            chain_reg   <= op;
        end else if (state_reg == RUN) begin
            partial_reg <= partial_next;
            chain_reg   <= cout_nib;
            idx_reg     <= idx_reg + IDXW'(1);
            if (last_nib) begin
                result   <= partial_next;
                carry    <= cout_nib;
                overflow <= (a_nib[NIB-1] == b_eff[NIB-1]) &&
                            (sum_nib[NIB-1] != a_nib[NIB-1]);
                zero     <= (partial_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Bench for nibble_serial_alu: a 16-bit instance for directed cases and an
// 8-bit instance under random back-to-back traffic, both compared every
// cycle against an arithmetic reference with completion timing.
module tb_nibble_serial_alu;

    localparam int WD[2] = '{16, 8};
    localparam int NN[2] = '{4, 2};

    logic        clk;
    logic        rst;
    logic        start_s [2];
    logic        op_s    [2];
    logic [15:0] a_s     [2];
    logic [15:0] b_s     [2];

    logic        busy16, done16, carry16, ovf16, zero16;
    logic [15:0] result16;
    logic        busy8, done8, carry8, ovf8, zero8;
    logic [7:0]  result8;

    logic        busy_o [2];
    logic        done_o [2];
    logic [18:0] out_o  [2];

    int errors = 0;
    int checks = 0;

    nibble_serial_alu #(.WIDTH(16)) u_dut16 (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s[0]),
        .op       (op_s[0]),
        .a        (a_s[0]),
        .b        (b_s[0]),
        .busy     (busy16),
        .done     (done16),
        .result   (result16),
        .carry    (carry16),
        .overflow (ovf16),
        .zero     (zero16)
    );

    nibble_serial_alu #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s[1]),
        .op       (op_s[1]),
        .a        (a_s[1][7:0]),
        .b        (b_s[1][7:0]),
        .busy     (busy8),
        .done     (done8),
        .result   (result8),
        .carry    (carry8),
        .overflow (ovf8),
        .zero     (zero8)
    );

    assign busy_o[0] = busy16;
    assign busy_o[1] = busy8;
    assign done_o[0] = done16;
    assign done_o[1] = done8;
    assign out_o[0]  = {zero16, ovf16, carry16, result16};
    assign out_o[1]  = {zero8, ovf8, carry8, 8'h00, result8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: returns {zero, overflow, carry, result[15:0]}
    function automatic logic [18:0] ref_op(input int w, input logic op,
                                           input logic [15:0] a_in,
                                           input logic [15:0] b_in);
        logic [15:0] mask, a, b, r;
        logic [16:0] full;
        logic        c, v, sa, sb, sr;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        a = a_in & mask;
        b = b_in & mask;
        if (op == 1'b0) begin
            full = {1'b0, a} + {1'b0, b};
            r    = full[15:0] & mask;
            c    = full[w];
        end else begin
            r    = (a - b) & mask;
            c    = (a >= b);
        end
        sa = a[w-1];
        sb = b[w-1];
        sr = r[w-1];
        v  = (op == 1'b0) ? (sa == sb && sr != sa) : (sa != sb && sr != sa);
        return {(r == 16'h0), v, c, r};
    endfunction

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)",
                     name, d, act, exp, $time);
        end
    endtask

    // Model state: edges since acceptance of the in-flight operation
    bit          infl     [2];
    int          t_m      [2];
    logic [18:0] pend     [2];
    logic [18:0] expo     [2];
    bit          exp_busy [2];
    bit          exp_done [2];

    // Behavioural model: busy for NN cycles after an accepted start, then
    // one done cycle in which the new outputs appear; new start accepted
    // only when idle or in the done cycle.
    always @(posedge clk or posedge rst) begin
        int t;
        bit f;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                infl[d]     <= 1'b0;
                t_m[d]      <= 0;
                expo[d]     <= '0;
                exp_busy[d] <= 1'b0;
                exp_done[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                f = infl[d];
                t = t_m[d] + (f ? 1 : 0);
                if (f && t == NN[d]) expo[d] <= pend[d];
                if (start_s[d] && (!f || t >= NN[d] + 1)) begin
                    f = 1'b1;
                    t = 0;
                    pend[d] <= ref_op(WD[d], op_s[d], a_s[d], b_s[d]);
                end
                infl[d]     <= f;
                t_m[d]      <= t;
                exp_busy[d] <= f && (t < NN[d]);
                exp_done[d] <= f && (t == NN[d]);
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                check("busy", d, 32'(busy_o[d]), 32'(exp_busy[d]));
                check("done", d, 32'(done_o[d]), 32'(exp_done[d]));
                check("outputs", d, 32'(out_o[d]), 32'(expo[d]));
                if (exp_done[d])
                    $display("dut%0d done: result=%h carry=%b ovf=%b zero=%b",
                             d, out_o[d][15:0], out_o[d][16], out_o[d][17], out_o[d][18]);
            end
        end
    end

    // Directed operation on the 16-bit instance with literal expectations
    task automatic run16(input logic op, input logic [15:0] a, input logic [15:0] b,
                         input logic [18:0] exp, input string tag);
        int lat;
        @(negedge clk);
        start_s[0] = 1'b1; op_s[0] = op; a_s[0] = a; b_s[0] = b;
        @(negedge clk);
        start_s[0] = 1'b0;
        lat = 1;
        while (!done16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 0, 32'(lat), 32'd5);
        check(tag, 0, 32'({zero16, ovf16, carry16, result16}), 32'(exp));
    endtask

    initial begin
        int dn;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; op_s[d] = 1'b0; a_s[d] = '0; b_s[d] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset_state16", 0, 32'({busy16, done16, zero16, ovf16, carry16, result16}), 32'd0);
        check("reset_state8", 1, 32'({busy8, done8, zero8, ovf8, carry8, result8}), 32'd0);
        rst = 1'b0;

        // Pin the reference model with hand-computed values
        check("model_add8", 1, 32'(ref_op(8, 1'b0, 16'h7F, 16'h01)), 32'({1'b0, 1'b1, 1'b0, 16'h0080}));
        check("model_sub8", 1, 32'(ref_op(8, 1'b1, 16'h80, 16'h01)), 32'({1'b0, 1'b1, 1'b1, 16'h007F}));

        // {zero, overflow, carry, result}
        run16(1'b0, 16'h7FFF, 16'h0001, {1'b0, 1'b1, 1'b0, 16'h8000}, "add_7fff_1");
        run16(1'b1, 16'h1234, 16'h1234, {1'b1, 1'b0, 1'b1, 16'h0000}, "sub_equal");
        run16(1'b1, 16'h0000, 16'h0001, {1'b0, 1'b0, 1'b0, 16'hFFFF}, "sub_0_1");
        run16(1'b1, 16'h8000, 16'h0001, {1'b0, 1'b1, 1'b1, 16'h7FFF}, "sub_8000_1");

        // Add with wrap, plus a start pulse while busy that must be ignored
        @(negedge clk);
        start_s[0] = 1'b1; op_s[0] = 1'b0; a_s[0] = 16'hFFFF; b_s[0] = 16'h0001;
        @(negedge clk);
        a_s[0] = 16'h0005;
        @(negedge clk);
        start_s[0] = 1'b0;
        dn = 2;
        while (!done16 && dn < 20) begin
            @(negedge clk);
            dn++;
        end
        check("add_ffff_1_latency", 0, 32'(dn), 32'd5);
        check("add_ffff_1", 0, 32'({zero16, ovf16, carry16, result16}), 32'({1'b1, 1'b0, 1'b1, 16'h0000}));
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done16) dn++;
        end
        check("ignored_start_dones", 0, 32'(dn), 32'd0);
        check("ignored_start_result", 0, 32'(result16), 32'h0000);

        // Reset mid-operation discards the in-flight add
        @(negedge clk);
        start_s[0] = 1'b1; op_s[0] = 1'b0; a_s[0] = 16'h00FF; b_s[0] = 16'h0001;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_midop", 0, 32'({busy16, done16, zero16, ovf16, carry16, result16}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done16) dn++;
        end
        check("no_done_after_reset", 0, 32'(dn), 32'd0);
        run16(1'b0, 16'h00FF, 16'h0001, {1'b0, 1'b0, 1'b0, 16'h0100}, "add_after_reset");

        // Random traffic on the 8-bit instance; start is frequently held
        // high so many operations are issued in the done cycle
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            start_s[1] = ($urandom_range(0, 3) != 0);
            op_s[1]    = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: a_s[1] = 16'h0000;
                    1: a_s[1] = 16'h007F;
                    2: a_s[1] = 16'h0080;
                    3: a_s[1] = 16'h00FF;
                    default: a_s[1] = 16'h0001;
                endcase
            end else begin
                a_s[1] = 16'($urandom_range(0, 255));
            end
            b_s[1] = 16'($urandom_range(0, 255));
        end
        @(negedge clk);
        start_s[1] = 1'b0;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
